// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: grant owner encoding
// and the arbitration FSM state.
package ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CPU_OWN    = 2'd1,
      DBG_OWN    = 2'd2,
      DBG_LOCKED = 2'd3
   } state_t;

   function automatic owner_t idle_pick(input logic cpu_req,
                                        input logic dbg_req);
      owner_t o;
      o = OWN_NONE;
      if (cpu_req)
         o = OWN_CPU;
      else if (dbg_req)
         o = OWN_DBG;
      return o;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_hold_counter.sv
// Saturating run-length counter: consecutive regrants to one owner.
// at_limit means the owner has used its last allowed regrant.
module arb_hold_counter #(
   parameter int MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic at_limit
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

   logic [CW-1:0] hold_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hold_cnt <= '0;
      else if (clear)
         hold_cnt <= '0;
      else if (inc && hold_cnt != LIMIT)
         hold_cnt <= hold_cnt + 1'b1;
   end

   assign at_limit = (hold_cnt == LIMIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one data RAM between the CPU load/store port and the
// debug/loader port: round-robin with bounded hold plus debug lock.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_W   = 19,
   parameter int ADDR_W   = 5,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              dbg_lock,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t state_q;
   state_t state_d;
   owner_t owner;
   logic   both;
   logic   at_limit;
   logic   same_owner;

   assign both = cpu_req & dbg_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Grant decision; a single requester always wins.
   always_comb begin
      owner = idle_pick(cpu_req, dbg_req);
      unique case (state_q)
         CPU_OWN:
            if (both && at_limit) owner = OWN_DBG;
         DBG_OWN:
            if (both && !at_limit) owner = OWN_DBG;
         DBG_LOCKED:
            if (dbg_req && dbg_lock) owner = OWN_DBG;
         default: ;
      endcase
      if (!reset)
         owner = OWN_NONE;
   end

   always_comb begin
      state_d = IDLE;
      unique case (owner)
         OWN_CPU: state_d = CPU_OWN;
         OWN_DBG: state_d = dbg_lock ? DBG_LOCKED : DBG_OWN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_gnt   = (owner == OWN_CPU);
      dbg_gnt   = (owner == OWN_DBG);
      cpu_stall = reset & cpu_req & ~cpu_gnt;
      ram_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
      ram_waddr = dbg_gnt ? dbg_addr : cpu_addr;
      ram_raddr = dbg_gnt ? dbg_addr : cpu_addr;
      ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
   end

   assign same_owner =
      (cpu_gnt && state_q == CPU_OWN) ||
      (dbg_gnt && (state_q == DBG_OWN ||
                   state_q == DBG_LOCKED));

   arb_hold_counter #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .clear    (~same_owner),
      .inc      (same_owner),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt & ~cpu_we;
         dbg_rvalid <= dbg_gnt & ~dbg_we;
         if (cpu_gnt && !cpu_we)
            cpu_rdata <= ram_rdata;
         if (dbg_gnt && !dbg_we)
            dbg_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, table vectors, directed
// corner sequences and randomized traffic against a reference model.
module tb_ram_port_arbiter;

   localparam int DW = 19;
   localparam int AW = 5;
   localparam int MH = 4;

   logic          clk;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          dbg_req, dbg_we, dbg_lock;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   logic [DW-1:0] mem [32];

   ram_port_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(MH)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata),
      .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_raddr(ram_raddr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_raddr];
   always @(posedge clk)
      if (ram_we) mem[ram_waddr] <= ram_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: previous owner (0 none, 1 cpu, 2 dbg),
   // length of its current grant run, and lock status.
   int            m_prev;
   int            m_run;
   bit            m_locked;
   logic [DW-1:0] shadow [32];
   logic          e_crv, e_drv;
   logic [DW-1:0] e_crd, e_drd;

   typedef struct {
      logic          cr, dr, dl;
      logic [AW-1:0] ca, da;
      logic          eg_c, eg_d;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = 0; m_run = 0; m_locked = 0;
      e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
   endtask

   task automatic model_gnt(input logic cr, input logic dr,
                            input logic dl,
                            output logic cg, output logic dg);
      cg = 0; dg = 0;
      if (m_locked && dr && dl) dg = 1;
      else if (cr && dr) begin
         if (m_locked || m_prev == 0) cg = 1;
         else if (m_run < MH) begin
            cg = (m_prev == 1); dg = (m_prev == 2);
         end else begin
            cg = (m_prev == 2); dg = (m_prev == 1);
         end
      end else begin
         cg = cr; dg = dr;
      end
   endtask

   task automatic model_update(
      input logic cg, input logic dg,
      input logic cw, input logic [AW-1:0] ca,
      input logic [DW-1:0] cd,
      input logic dw, input logic dl,
      input logic [AW-1:0] da, input logic [DW-1:0] dd);
      int own;
      e_crv = cg & ~cw;
      e_drv = dg & ~dw;
      if (e_crv) e_crd = shadow[ca];
      if (e_drv) e_drd = shadow[da];
      if (cg && cw) shadow[ca] = cd;
      if (dg && dw) shadow[da] = dd;
      own = cg ? 1 : (dg ? 2 : 0);
      if (own == 0) m_run = 0;
      else if (own == m_prev) m_run = (m_run < MH) ? m_run + 1 : MH;
      else m_run = 1;
      m_prev = own;
      m_locked = dg & dl;
   endtask

   // Called just after a falling edge; returns with the next one.
   task automatic step(
      input logic cr, input logic cw, input logic [AW-1:0] ca,
      input logic [DW-1:0] cd,
      input logic dr, input logic dw, input logic dl,
      input logic [AW-1:0] da, input logic [DW-1:0] dd,
      output logic acg, output logic adg);
      logic cg, dg;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_lock = dl;
      dbg_addr = da; dbg_wdata = dd;
      #1;
      model_gnt(cr, dr, dl, cg, dg);
      acg = cpu_gnt; adg = dbg_gnt;
      chk("cpu_gnt", 32'(cpu_gnt), 32'(cg));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(dg));
      chk("cpu_stall", 32'(cpu_stall), 32'(cr & ~cg));
      chk("ram_we", 32'(ram_we), 32'((cg & cw) | (dg & dw)));
      if (cg || dg) begin
         chk("ram_raddr", 32'(ram_raddr), 32'(cg ? ca : da));
         chk("ram_waddr", 32'(ram_waddr), 32'(cg ? ca : da));
         if ((cg && cw) || (dg && dw))
            chk("ram_wdata", 32'(ram_wdata), 32'(cg ? cd : dd));
      end
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
      chk("dbg_rdata", 32'(dbg_rdata), 32'(e_drd));
      @(posedge clk);
      model_update(cg, dg, cw, ca, cd, dw, dl, da, dd);
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
      chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 0);
      chk({tag, "_stall"}, 32'(cpu_stall), 0);
      chk({tag, "_ram_we"}, 32'(ram_we), 0);
      chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
      chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 0);
      chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
      chk({tag, "_dbg_rdata"}, 32'(dbg_rdata), 0);
   endtask

   function automatic vec_t mk(input logic cr, input logic dr,
                               input logic dl, input int i,
                               input logic ec, input logic ed);
      vec_t v;
      v.cr = cr; v.dr = dr; v.dl = dl;
      v.ca = AW'(i); v.da = AW'(31 - i);
      v.eg_c = ec; v.eg_d = ed;
      return v;
   endfunction

   initial begin
      logic g_c, g_d;
      model_reset();
      reset = 1'b0;
      cpu_req = 1; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1; dbg_we = 1; dbg_lock = 0;
      dbg_addr = '0; dbg_wdata = '0;

      // Reset held with both requesting.
      repeat (3) @(negedge clk);
      #1 reset_checks("rst_hold");
      @(negedge clk);
      reset = 1'b1;
      step(1, 0, 5'd3, '0, 1, 0, 0, 5'd4, '0, g_c, g_d);
      chk("first_cpu_win", 32'(g_c), 1);

      // Fill RAM through the debug port.
      for (int a = 0; a < 32; a++)
         step(0, 0, '0, '0, 1, 1, 0, AW'(a),
              DW'($urandom), g_c, g_d);

      // Lone CPU read after a debug write.
      step(0, 0, '0, '0, 1, 1, 0, 5'd5, 19'h12345, g_c, g_d);
      step(1, 0, 5'd5, '0, 0, 0, 0, '0, '0, g_c, g_d);
      chk("rd5_gnt", 32'(g_c), 1);
      #1;
      chk("rd5_rvalid", 32'(cpu_rvalid), 1);
      chk("rd5_rdata", 32'(cpu_rdata), 32'h12345);
      @(negedge clk);

      // Round-robin hold and debug lock vectors.
      tbl[0] = mk(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) tbl[i] = mk(1, 1, 0, i, 1, 0);
      for (int i = 5; i <= 8; i++) tbl[i] = mk(1, 1, 0, i, 0, 1);
      for (int i = 9; i <= 12; i++) tbl[i] = mk(1, 1, 1, i, 1, 0);
      for (int i = 13; i <= 22; i++) tbl[i] = mk(1, 1, 1, i, 0, 1);
      tbl[23] = mk(1, 1, 0, 23, 1, 0);
      tbl[24] = mk(0, 0, 0, 24, 0, 0);
      for (int i = 0; i < 25; i++) begin
         step(tbl[i].cr, 0, tbl[i].ca, '0,
              tbl[i].dr, 0, tbl[i].dl, tbl[i].da, '0, g_c, g_d);
         chk($sformatf("tbl%0d_cpu_gnt", i), 32'(g_c),
             32'(tbl[i].eg_c));
         chk($sformatf("tbl%0d_dbg_gnt", i), 32'(g_d),
             32'(tbl[i].eg_d));
      end

      // Debug write to top address, then CPU read of it.
      step(0, 0, '0, '0, 1, 1, 0, 5'd31, 19'h7FFFF, g_c, g_d);
      step(1, 0, 5'd31, '0, 0, 0, 0, '0, '0, g_c, g_d);
      #1;
      chk("rd31_rdata", 32'(cpu_rdata), 32'h7FFFF);
      @(negedge clk);

      // Randomized traffic.
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 3) != 0, 1'($urandom),
              AW'($urandom), DW'($urandom),
              $urandom_range(0, 2) != 0, 1'($urandom),
              $urandom_range(0, 3) == 0,
              AW'($urandom), DW'($urandom), g_c, g_d);

      // Reset while locked with a debug read just granted.
      repeat (3)
         step(1, 0, 5'd1, '0, 1, 0, 1, 5'd9, '0, g_c, g_d);
      #1;
      chk("lock_pre_rvalid", 32'(dbg_rvalid), 1);
      reset = 1'b0;
      #1 reset_checks("rst_mid");
      @(negedge clk);
      #1 reset_checks("rst_mid2");
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      step(1, 0, 5'd2, '0, 1, 0, 1, 5'd9, '0, g_c, g_d);
      chk("post_rst_cpu_win", 32'(g_c), 1);
      step(0, 0, '0, '0, 0, 0, 0, '0, '0, g_c, g_d);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
